seg7_scan_display: RTL

Parametrised, time-multiplexed driver for a bank of common-anode seven-segment digits, each showing one hex nibble. It extends the single-digit hex-to-segment decode with a digit-scan counter, per-digit decimal point, a double-buffered display value that updates only at frame boundaries, and anti-ghosting blanking. It sits between the counter/datapath logic and the board's segment and anode pins.

---
 rtl/seg7_scan_display.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_display
// Purpose  : Time-multiplexed common-anode 7-segment driver with a frame-synchronous
//            double-buffered value and anti-ghost blanking.
//            Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_display #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    update_pending,
    output logic                    frame_tick
);

    localparam int c_PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [c_PRE_W-1:0]    c_PRE_LAST = c_PRE_W'(CLK_DIV - 1);
    localparam logic [c_IDX_W-1:0]    c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_ONE      = NUM_DIGITS'(1);

    logic [c_PRE_W-1:0]      r_presc;
    logic [c_IDX_W-1:0]      r_idx;
    logic [4*NUM_DIGITS-1:0] r_pend_val;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic                    r_pend_vld;
    logic [4*NUM_DIGITS-1:0] r_shadow_val;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;
    logic                    r_wrap;
    logic                    r_frame_tick;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;

    logic                    w_slot_end;
    logic                    w_frame_end;
    logic [3:0]              w_cur_nib;
    logic                    w_cur_dp;
    logic                    w_cur_blank;
    logic [NUM_DIGITS-1:0]   w_blank_mask;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    assign w_slot_end  = (r_presc == c_PRE_LAST);
    assign w_frame_end = w_slot_end && (r_idx == c_IDX_LAST);

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] w_zero_from;
    logic                  w_zero_run;

    // w_zero_from[k]: nibble k and every more-significant nibble are zero
    always_comb begin
        w_zero_from = '0;
        w_zero_run  = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_zero_run     = w_zero_run && (r_shadow_val[4*k +: 4] == 4'd0);
            w_zero_from[k] = w_zero_run;
        end
    end

    assign w_blank_mask = w_zero_from & ~c_ONE;
`else
    assign w_blank_mask = '0;
`endif

    always_comb begin
        w_cur_nib   = '0;
        w_cur_dp    = 1'b0;
        w_cur_blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == c_IDX_W'(k)) begin
                w_cur_nib   = r_shadow_val[4*k +: 4];
                w_cur_dp    = r_shadow_dp[k];
                w_cur_blank = w_blank_mask[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_pend_vld   <= 1'b0;
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_wrap       <= 1'b0;
            r_frame_tick <= 1'b0;
            r_seg        <= '1;
            r_dp         <= 1'b1;
            r_an         <= '1;
        end else begin
            r_presc <= w_slot_end ? '0 : r_presc + c_PRE_W'(1);
            if (w_slot_end) begin
                r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_W'(1);
            end

            // A load landing on the boundary bypasses the pending buffer
            if (w_frame_end) begin
                if (load) begin
                    r_shadow_val <= value_in;
                    r_shadow_dp  <= dp_in;
                end else if (r_pend_vld) begin
                    r_shadow_val <= r_pend_val;
                    r_shadow_dp  <= r_pend_dp;
                end
                r_pend_vld <= 1'b0;
            end else if (load) begin
                r_pend_val <= value_in;
                r_pend_dp  <= dp_in;
                r_pend_vld <= 1'b1;
            end

            // Delayed twice so the tick lines up with the new frame's first output cycle
            r_wrap       <= w_frame_end;
            r_frame_tick <= r_wrap;

            if (r_presc == '0) begin
                r_seg <= '1;
                r_dp  <= 1'b1;
                r_an  <= '1;
            end else begin
                r_seg <= w_cur_blank ? 7'b1111111 : seg_decode(w_cur_nib);
                r_dp  <= ~w_cur_dp;
                r_an  <= ~(c_ONE << r_idx);
            end
        end
    end

    assign seg_out        = r_seg;
    assign dp_out         = r_dp;
    assign an_out         = r_an;
    assign update_pending = r_pend_vld;
    assign frame_tick     = r_frame_tick;

endmodule
`default_nettype wire
